// File: rtl/alu_pipe_if.sv
// Operand/result channel of alu_pipe: valid/ready input and output handshakes
// plus the registered result and flag outputs.
interface alu_pipe_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_hi;
  logic             car;
  logic             of;
  logic             zf;
  logic             nf;
  logic             err;
  logic             busy;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, res, res_hi, car, of, zf, nf, err, busy
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, res, res_hi, car, of, zf, nf, err, busy
  );
endinterface

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle logic/arithmetic ops with registered result and
// flags, plus a WIDTH-cycle shift-add unsigned multiply. One transaction in flight.
module alu_pipe #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_pipe_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_NOT = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SLT = 4'd6;
  localparam logic [3:0] OP_EQ  = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   res_hi_q, res_hi_d;
  logic               car_q, car_d;
  logic               of_q, of_d;
  logic               zf_q, zf_d;
  logic               nf_q, nf_d;
  logic               err_q, err_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [WIDTH:0]     sum, diff;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_car, alu_of, alu_err;
  logic [2*WIDTH-1:0] acc_nxt;

  // Single-cycle datapath; sub is a + ~b + 1 so carry-out means "no borrow".
  always_comb begin
    sum     = {1'b0, bus.a} + {1'b0, bus.b};
    diff    = {1'b0, bus.a} + {1'b0, ~bus.b} + (WIDTH+1)'(1);
    alu_res = '0;
    alu_car = 1'b0;
    alu_of  = 1'b0;
    alu_err = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_car = sum[WIDTH];
        alu_of  = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff[WIDTH-1:0];
        alu_car = diff[WIDTH];
        alu_of  = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_NOT:  alu_res = ~bus.a;
      OP_AND:  alu_res = bus.a & bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_XOR:  alu_res = bus.a ^ bus.b;
      OP_SLT:  alu_res = WIDTH'($signed(bus.a) < $signed(bus.b));
      OP_EQ:   alu_res = WIDTH'(bus.a == bus.b);
      default: alu_err = 1'b1;
    endcase
  end

  assign acc_nxt = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    res_hi_d = res_hi_q;
    car_d    = car_q;
    of_d     = of_q;
    zf_d     = zf_q;
    nf_d     = nf_q;
    err_d    = err_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          if (bus.op == OP_MUL) begin
            mcand_d  = {{WIDTH{1'b0}}, bus.a};
            mplier_d = bus.b;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = S_MUL;
          end else begin
            res_d    = alu_res;
            res_hi_d = '0;
            car_d    = alu_car;
            of_d     = alu_of;
            zf_d     = (alu_res == '0);
            nf_d     = alu_res[WIDTH-1];
            err_d    = alu_err;
            state_d  = S_DONE;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_nxt;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          res_d    = acc_nxt[WIDTH-1:0];
          res_hi_d = acc_nxt[2*WIDTH-1:WIDTH];
          car_d    = (acc_nxt[2*WIDTH-1:WIDTH] != '0);
          of_d     = 1'b0;
          zf_d     = (acc_nxt[WIDTH-1:0] == '0);
          nf_d     = acc_nxt[WIDTH-1];
          err_d    = 1'b0;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      res_q    <= '0;
      res_hi_q <= '0;
      car_q    <= 1'b0;
      of_q     <= 1'b0;
      zf_q     <= 1'b0;
      nf_q     <= 1'b0;
      err_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      res_hi_q <= res_hi_d;
      car_q    <= car_d;
      of_q     <= of_d;
      zf_q     <= zf_d;
      nf_q     <= nf_d;
      err_q    <= err_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  // in_ready is gated by rst_n so it reads 0 for the whole reset pulse.
  assign bus.in_ready  = rst_n && (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q == S_MUL);
  assign bus.res       = res_q;
  assign bus.res_hi    = res_hi_q;
  assign bus.car       = car_q;
  assign bus.of        = of_q;
  assign bus.zf        = zf_q;
  assign bus.nf        = nf_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (WIDTH=8) with hand-computed expected results.
module tb_alu_pipe;
  logic clk;
  logic rst_n;
  int unsigned total;
  int unsigned bad;

  alu_pipe_if #(.WIDTH(8)) bus ();

  alu_pipe #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flag vector order: {car, of, zf, nf, err}
  function automatic logic [4:0] flags();
    return {bus.car, bus.of, bus.zf, bus.nf, bus.err};
  endfunction

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    @(negedge clk);
    bus.a = a;
    bus.b = b;
    bus.op = op;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic consume();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  // Issues a single-cycle op, checks latency-1 result and flags, then drains it.
  task automatic run_single(input string name, input logic [7:0] a, input logic [7:0] b,
                            input logic [3:0] op, input logic [7:0] exp_res,
                            input logic [4:0] exp_flags);
    issue(a, b, op);
    total++;
    if (bus.out_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s valid: got %b want 1", name, bus.out_valid);
    end
    total++;
    if ({bus.res_hi, bus.res} !== {8'h00, exp_res}) begin
      bad++;
      $display("FAIL %s res: got %h want %h", name, {bus.res_hi, bus.res}, {8'h00, exp_res});
    end
    total++;
    if (flags() !== exp_flags) begin
      bad++;
      $display("FAIL %s flags(c,o,z,n,e): got %b want %b", name, flags(), exp_flags);
    end
    consume();
    total++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL %s drain(ov,ir): got %b want 01", name, {bus.out_valid, bus.in_ready});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.op = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.in_ready, bus.out_valid, bus.busy} !== 3'b000) begin
      bad++;
      $display("FAIL reset hs(ir,ov,busy): got %b want 000", {bus.in_ready, bus.out_valid, bus.busy});
    end
    total++;
    if ({bus.res_hi, bus.res, flags()} !== 21'h0) begin
      bad++;
      $display("FAIL reset outs: got %h want 0", {bus.res_hi, bus.res, flags()});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset release in_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_add();
    run_single("add7f01", 8'h7F, 8'h01, 4'd0, 8'h80, 5'b01010);
    run_single("addffff", 8'hFF, 8'hFF, 4'd0, 8'hFE, 5'b10010);
  endtask

  task automatic test_sub();
    run_single("sub0505", 8'h05, 8'h05, 4'd1, 8'h00, 5'b10100);
    run_single("sub8001", 8'h80, 8'h01, 4'd1, 8'h7F, 5'b11000);
    run_single("sub0102", 8'h01, 8'h02, 4'd1, 8'hFF, 5'b00010);
  endtask

  task automatic test_logic();
    run_single("not", 8'hA5, 8'h0F, 4'd2, 8'h5A, 5'b00000);
    run_single("and", 8'hA5, 8'h0F, 4'd3, 8'h05, 5'b00000);
    run_single("or",  8'hA5, 8'h0F, 4'd4, 8'hAF, 5'b00010);
    run_single("xor", 8'hA5, 8'h0F, 4'd5, 8'hAA, 5'b00010);
    run_single("slt_t", 8'hFF, 8'h01, 4'd6, 8'h01, 5'b00000);
    run_single("slt_f", 8'h01, 8'hFF, 4'd6, 8'h00, 5'b00100);
    run_single("eq_t", 8'h3C, 8'h3C, 4'd7, 8'h01, 5'b00000);
    run_single("eq_f", 8'h3C, 8'h3D, 4'd7, 8'h00, 5'b00100);
  endtask

  task automatic run_mul(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] exp_prod, input logic [4:0] exp_flags);
    int edges;
    issue(a, b, 4'd8);
    edges = 1;
    while (bus.out_valid !== 1'b1 && edges < 20) begin
      total++;
      if ({bus.busy, bus.in_ready} !== 2'b10) begin
        bad++;
        $display("FAIL %s busy(b,ir) edge %0d: got %b want 10", name, edges, {bus.busy, bus.in_ready});
      end
      @(posedge clk);
      #1;
      edges++;
    end
    total++;
    if (edges != 9) begin
      bad++;
      $display("FAIL %s latency: got %0d edges want 9", name, edges);
    end
    total++;
    if ({bus.res_hi, bus.res} !== exp_prod) begin
      bad++;
      $display("FAIL %s prod: got %h want %h", name, {bus.res_hi, bus.res}, exp_prod);
    end
    total++;
    if ({flags(), bus.busy} !== {exp_flags, 1'b0}) begin
      bad++;
      $display("FAIL %s flags+busy: got %b want %b", name, {flags(), bus.busy}, {exp_flags, 1'b0});
    end
    consume();
  endtask

  task automatic test_mul();
    run_mul("mulffff", 8'hFF, 8'hFF, 16'hFE01, 5'b10000);
    run_mul("mul0d0b", 8'h0D, 8'h0B, 16'h008F, 5'b00010);
    run_mul("mul0010", 8'h00, 8'h10, 16'h0000, 5'b00100);
  endtask

  task automatic test_back_to_back();
    logic [20:0] snap;
    issue(8'h12, 8'h34, 4'd0);
    snap = {bus.res_hi, bus.res, flags()};
    total++;
    if (snap !== {8'h00, 8'h46, 5'b00000}) begin
      bad++;
      $display("FAIL bp first: got %h want %h", snap, {8'h00, 8'h46, 5'b00000});
    end
    @(negedge clk);
    bus.a = 8'hFF;
    bus.b = 8'hFF;
    bus.op = 4'd3;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      total++;
      if ({bus.out_valid, bus.in_ready, bus.res_hi, bus.res, flags()} !== {2'b10, snap}) begin
        bad++;
        $display("FAIL bp hold %0d: got %h want %h", i,
                 {bus.out_valid, bus.in_ready, bus.res_hi, bus.res, flags()}, {2'b10, snap});
      end
    end
    bus.in_valid = 1'b0;
    consume();
    total++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL bp release(ov,ir): got %b want 01", {bus.out_valid, bus.in_ready});
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp no capture: got %b want 0", bus.out_valid);
    end
  endtask

  task automatic test_illegal();
    issue(8'h12, 8'h34, 4'd12);
    total++;
    if ({bus.out_valid, bus.res_hi, bus.res, flags()} !== {1'b1, 16'h0000, 5'b00101}) begin
      bad++;
      $display("FAIL illegal: got %h want %h", {bus.out_valid, bus.res_hi, bus.res, flags()},
               {1'b1, 16'h0000, 5'b00101});
    end
    consume();
    run_single("legal_after_err", 8'h01, 8'h01, 4'd3, 8'h01, 5'b00000);
  endtask

  task automatic test_reset_mid_mul();
    issue(8'hFF, 8'hFF, 4'd8);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.in_ready, bus.out_valid, bus.busy, bus.res_hi, bus.res, flags()} !== 24'h0) begin
      bad++;
      $display("FAIL mid-mul reset: got %h want 0",
               {bus.in_ready, bus.out_valid, bus.busy, bus.res_hi, bus.res, flags()});
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_single("add_after_rst", 8'h12, 8'h34, 4'd0, 8'h46, 5'b00000);
  endtask

  initial begin
    total = 0;
    bad = 0;
    fork
      begin
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_mul();
        test_back_to_back();
        test_illegal();
        test_reset_mid_mul();
      end
      begin
        #200000;
        bad++;
        $display("FAIL timeout: got no completion want completion");
      end
    join_any
    disable fork;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
